regfile_param: RTL

- Parametrised successor to the single-issue 64-bit x 32 register file in the RISC-V datapath.
- Keeps synchronous write and asynchronous read, and adds:
  - configurable width and depth
  - hardwired-zero register 0
  - write-to-read bypass
  - pending-write scoreboard for pipeline hazard detection
  - sequential clear engine that zeroes the file one entry per cycle on request

---
 rtl/regfile_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with synchronous write,
// combinational read, write-to-read bypass, pending-write scoreboard and
// a sequential clear engine that zeroes one entry per cycle.
// Optional feature macro: REGFILE_PARITY_EN adds one stored even-parity bit
// per entry and the ParityErr1/ParityErr2 outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal operation; writes, reservations and bypass allowed
// S_CLEAR | busy; entry idx_q is zeroed each cycle, all other traffic dropped
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              Pending1,
  output logic              Pending2,
  input  logic              clear_req,
  output logic              busy
`ifdef REGFILE_PARITY_EN
  ,
  output logic              ParityErr1,
  output logic              ParityErr2
`endif
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clr_start;

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] sb_q, sb_d;

  logic wr_en, rsv_en;
  logic rs1_zero, rs2_zero;
  logic byp1, byp2;

  // Index 0 is hardwired only when ZERO_REG is set.
  assign rs1_zero = ZERO_REG && (RS1 == '0);
  assign rs2_zero = ZERO_REG && (RS2 == '0);

  assign wr_en  = RegWrite  && !busy && !(ZERO_REG && (RD == '0));
  assign rsv_en = rsv_valid && !busy && !(ZERO_REG && (rsv_rd == '0));

  assign byp1 = wr_en && (RD == RS1);
  assign byp2 = wr_en && (RD == RS2);

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear engine next state: walk every index once, then return to idle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy      = 1'b0;
    clr_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          idx_d     = '0;
          clr_start = 1'b1;
        end
      end
      S_CLEAR: begin
        busy  = 1'b1;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage: reset wipes everything, clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[idx_q] <= '0;
    end else if (wr_en) begin
      mem[RD] <= WriteData;
    end
  end

  // Scoreboard next value: a same-cycle reservation overrides the write's release.
  always_comb begin
    sb_d = sb_q;
    if (clr_start) begin
      sb_d = '0;
    end else begin
      if (wr_en)  sb_d[RD]     = 1'b0;
      if (rsv_en) sb_d[rsv_rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign ReadData1 = rs1_zero ? '0 : (byp1 ? WriteData : mem[RS1]);
  assign ReadData2 = rs2_zero ? '0 : (byp2 ? WriteData : mem[RS2]);
  assign Pending1  = !rs1_zero && sb_q[RS1];
  assign Pending2  = !rs2_zero && sb_q[RS2];

`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] par_q;

  // Parity bits follow the data array; zero data always carries parity 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      par_q <= '0;
    end else if (busy) begin
      par_q[idx_q] <= 1'b0;
    end else if (wr_en) begin
      par_q[RD] <= ^WriteData;
    end
  end

  assign ParityErr1 = !rs1_zero && !byp1 && (par_q[RS1] ^ (^mem[RS1]));
  assign ParityErr2 = !rs2_zero && !byp2 && (par_q[RS2] ^ (^mem[RS2]));
`endif

endmodule
